// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction fetch with a DEPTH-entry prefetch queue.
// Issues word fetches over req/gnt/rvalid, buffers {instr, pc, fault} and
// hands the head to decode with valid/ready. Redirects flush everything and
// drop responses still in flight.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect target
// yields one fault entry and halts fetch until the next redirect).
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        fault_o
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  // Dropped responses can pile up across back-to-back redirects with a slow
  // memory, so the discard counter is much wider than the credit counters.
  localparam int unsigned DW = 16;
  localparam logic [CW:0] CAP = (CW+1)'(DEPTH);

  logic [31:0]   fpc;       // next fetch address
  logic [31:0]   rpc;       // pc of the next live response
  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pc_q    [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] out_cnt;   // live requests in flight (their data is kept)
  logic [DW-1:0] disc_cnt;  // requests in flight whose data must be dropped

  logic          halted;
  logic          fault_pend;
  logic [31:0]   target;

  logic [CW:0]   used;
  logic          req, gnt, rsp, drop, push_rsp, push, pop;
  logic [CW-1:0] out_acc;
  logic [DW-1:0] disc_acc;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic             misalign;
  logic [DEPTH-1:0] fault_q;

  assign target   = redirect_pc_i;
  assign misalign = |redirect_pc_i[1:0];
  assign fault_o  = fault_q[rd_ptr];

  // Halt/fault-entry control: a misaligned target halts fetch and queues one
  // fault entry in the cycle after the redirect.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      halted     <= 1'b0;
      fault_pend <= 1'b0;
      fault_q    <= '0;
    end else if (redirect_i) begin
      halted     <= misalign;
      fault_pend <= misalign;
    end else begin
      fault_pend <= 1'b0;
      if (push) fault_q[wr_ptr] <= fault_pend;
    end
  end
`else
  // Low target bits are simply ignored; fetch stays word aligned.
  assign target     = redirect_pc_i & 32'hFFFF_FFFC;
  assign halted     = 1'b0;
  assign fault_pend = 1'b0;
  assign fault_o    = 1'b0;
`endif

  // Credit: queued entries plus live fetches never exceed DEPTH, so a live
  // response always finds a free slot.
  assign used     = {1'b0, count} + {1'b0, out_cnt};
  assign req      = !rst_i && !redirect_i && !halted && (used < CAP);
  assign gnt      = req && imem_gnt_i;
  // A response with nothing in flight is a protocol error and is ignored.
  assign rsp      = imem_rvalid_i && ((out_cnt != '0) || (disc_cnt != '0));
  assign drop     = rsp && (disc_cnt != '0);
  assign push_rsp = rsp && (disc_cnt == '0);
  assign push     = push_rsp || fault_pend;
  assign pop      = instr_valid_o && instr_ready_i;

  assign out_acc  = out_cnt + CW'(gnt) - CW'(push_rsp);
  assign disc_acc = disc_cnt - DW'(drop);

  assign imem_req_o    = req;
  assign imem_addr_o   = fpc;
  assign instr_valid_o = (count != '0);
  assign instr_o       = instr_q[rd_ptr];
  assign pc_o          = pc_q[rd_ptr];
  assign pc_plus4_o    = pc_o + 32'd4;

  // Control state: fetch pc, response pc, pointers and the three counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fpc      <= RESET_PC;
      rpc      <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      out_cnt  <= '0;
      disc_cnt <= '0;
    end else if (redirect_i) begin
      // Everything still in flight belongs to the old path: move it all to
      // the discard count after this cycle's response has been accounted.
      fpc      <= target;
      rpc      <= target;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      out_cnt  <= '0;
      disc_cnt <= disc_acc + DW'(out_acc);
    end else begin
      if (gnt)      fpc    <= fpc + 32'd4;
      if (push_rsp) rpc    <= rpc + 32'd4;
      if (push)     wr_ptr <= wr_ptr + PW'(1);
      if (pop)      rd_ptr <= rd_ptr + PW'(1);
      count    <= count + CW'(push) - CW'(pop);
      out_cnt  <= out_acc;
      disc_cnt <= disc_acc;
    end
  end

  // Queue storage; a fault entry carries a zero instruction word.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else if (!redirect_i && push) begin
      instr_q[wr_ptr] <= push_rsp ? imem_rdata_i : 32'h0;
      pc_q[wr_ptr]    <= rpc;
    end
  end

  // Every response must match a request still in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_i) assert (!imem_rvalid_i || (out_cnt != '0) || (disc_cnt != '0));
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: vector table for reset/stream/stall, hand sequences for
// redirect corners, then randomized traffic against a stream-level model.
module tb_fetch_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        fault_o;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk_i(clk), .rst_i(rst),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_o(instr_o), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o), .fault_o(fault_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // memory model: in-order responses, one per grant
  typedef struct { logic [31:0] addr; int due; } rsp_t;
  rsp_t mq[$];
  int cyc, last_due, gnt_pct, lat_lo, lat_hi, n_deliv;

  // stream model
  logic [31:0] exp_fetch, exp_pc;
  bit m_halt, m_fpend, m_dead;

  // snapshot of DUT outputs for the current cycle
  logic        s_req, s_valid, s_fault, s_rvalid;
  logic [31:0] s_addr, s_pc, s_plus4, s_instr;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; redirect_i = 1'b0; instr_ready_i = 1'b0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0;
    mq.delete();
    @(negedge clk);
    #1;
    chk("rst_req", imem_req_o, 0);
    chk("rst_valid", instr_valid_o, 0);
    chk("rst_instr", instr_o, 0);
    chk("rst_pc", pc_o, 0);
    chk("rst_pc_plus4", pc_plus4_o, 32'h4);
    chk("rst_fault", fault_o, 0);
    cyc = 0; last_due = 0;
    exp_fetch = 32'h0; exp_pc = 32'h0;
    m_halt = 0; m_fpend = 0; m_dead = 0;
  endtask

  // One clock cycle: drive inputs, snapshot outputs, run the model checks.
  task automatic step(input logic rdy, input logic redir, input logic [31:0] tgt);
    int due;
    @(negedge clk);
    rst = 1'b0;
    instr_ready_i = rdy; redirect_i = redir; redirect_pc_i = tgt;
    imem_gnt_i = ($urandom_range(99) < gnt_pct);
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid_i = 1'b1; imem_rdata_i = memf(mq[0].addr);
    end else begin
      imem_rvalid_i = 1'b0; imem_rdata_i = $urandom;
    end
    #1;
    s_req = imem_req_o; s_addr = imem_addr_o; s_valid = instr_valid_o;
    s_pc = pc_o; s_plus4 = pc_plus4_o; s_instr = instr_o; s_fault = fault_o;
    s_rvalid = imem_rvalid_i;

    if (redir) chk("req_in_redirect", s_req, 0);
    if (m_halt && !redir) chk("req_while_halted", s_req, 0);
    if (imem_rvalid_i) void'(mq.pop_front());
    if (s_req && imem_gnt_i) begin
      chk("fetch_addr", s_addr, exp_fetch);
      exp_fetch = exp_fetch + 32'd4;
      due = cyc + $urandom_range(lat_lo, lat_hi);
      if (due < last_due) due = last_due;
      last_due = due;
      mq.push_back('{addr: s_addr, due: due});
    end
    if (!redir && m_dead) chk("valid_after_fault", s_valid, 0);
    else if (!redir && s_valid && rdy) begin
      n_deliv++;
      chk("deliver_pc", s_pc, exp_pc);
      chk("deliver_plus4", s_plus4, exp_pc + 32'd4);
      if (m_fpend) begin
        chk("deliver_fault", s_fault, 1);
        chk("deliver_fault_instr", s_instr, 0);
        m_fpend = 0; m_dead = 1;
      end else begin
        chk("deliver_fault", s_fault, 0);
        chk("deliver_instr", s_instr, memf(exp_pc));
        exp_pc = exp_pc + 32'd4;
      end
    end
    if (redir) begin
      m_fpend = 0; m_dead = 0; m_halt = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
      exp_pc = tgt; exp_fetch = tgt;
      if (tgt[1:0] != 2'b00) begin m_halt = 1; m_fpend = 1; end
`else
      exp_pc = {tgt[31:2], 2'b00}; exp_fetch = exp_pc;
`endif
    end
    cyc++;
  endtask

  task automatic run_until_valid(input int max, output int n);
    n = 0;
    do begin step(1'b1, 1'b0, 32'h0); n++; end while (!s_valid && n < max);
  endtask

  typedef struct {
    bit rst; bit rdy; bit e_req; logic [31:0] e_addr; bit e_valid; logic [31:0] e_pc;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(bit r, bit rdy, bit rq, logic [31:0] a, bit v, logic [31:0] p);
    tbl.push_back('{rst: r, rdy: rdy, e_req: rq, e_addr: a, e_valid: v, e_pc: p});
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    logic [31:0] tgt;
    rst = 1'b1; redirect_i = 0; redirect_pc_i = 0; instr_ready_i = 0;
    imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0;
    gnt_pct = 100; lat_lo = 1; lat_hi = 1; n_deliv = 0; cyc = 0; last_due = 0;
    exp_fetch = 0; exp_pc = 0; m_halt = 0; m_fpend = 0; m_dead = 0;

    // streaming, 1-cycle memory, decode always ready
    add(1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 32'h00, 0, 0);
    add(0, 1, 1, 32'h04, 0, 0);
    add(0, 1, 1, 32'h08, 1, 32'h00);
    add(0, 1, 1, 32'h0C, 1, 32'h04);
    add(0, 1, 1, 32'h10, 1, 32'h08);
    add(0, 1, 1, 32'h14, 1, 32'h0C);
    add(0, 1, 1, 32'h18, 1, 32'h10);
    // decode stall: exactly DEPTH grants, head held on pc 0
    add(1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 32'h00, 0, 0);
    add(0, 0, 1, 32'h04, 0, 0);
    add(0, 0, 1, 32'h08, 1, 32'h00);
    add(0, 0, 1, 32'h0C, 1, 32'h00);
    for (int i = 0; i < 8; i++) add(0, 0, 0, 0, 1, 32'h00);
    add(0, 1, 0, 0,      1, 32'h00);
    add(0, 1, 1, 32'h10, 1, 32'h04);
    add(0, 1, 1, 32'h14, 1, 32'h08);
    add(0, 1, 1, 32'h18, 1, 32'h0C);
    add(0, 1, 1, 32'h1C, 1, 32'h10);
    add(0, 1, 1, 32'h20, 1, 32'h14);

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      else begin
        step(tbl[i].rdy, 1'b0, 32'h0);
        chk($sformatf("vec%0d_req", i), s_req, tbl[i].e_req);
        if (tbl[i].e_req) chk($sformatf("vec%0d_addr", i), s_addr, tbl[i].e_addr);
        chk($sformatf("vec%0d_valid", i), s_valid, tbl[i].e_valid);
        if (tbl[i].e_valid) begin
          chk($sformatf("vec%0d_pc", i), s_pc, tbl[i].e_pc);
          chk($sformatf("vec%0d_instr", i), s_instr, memf(tbl[i].e_pc));
        end
      end
    end

    // 3-cycle memory, redirect with three fetches in flight
    lat_lo = 3; lat_hi = 3;
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h100);
    chk("s3_rvalid_at_redirect", s_rvalid, 1);
    run_until_valid(20, n);
    chk("s3_valid", s_valid, 1);
    chk("s3_head_pc", s_pc, 32'h100);
    chk("s3_latency", n, 5);

    // redirect coincident with pop and rvalid
    lat_lo = 1; lat_hi = 1;
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h300);
    chk("s4_pre_valid", s_valid, 1);
    chk("s4_pre_rvalid", s_rvalid, 1);
    step(1'b1, 1'b0, 32'h0);
    chk("s4_req", s_req, 1);
    chk("s4_addr", s_addr, 32'h300);
    chk("s4_valid_n1", s_valid, 0);
    step(1'b1, 1'b0, 32'h0);
    chk("s4_valid_n2", s_valid, 0);
    step(1'b1, 1'b0, 32'h0);
    chk("s4_valid_n3", s_valid, 1);
    chk("s4_pc_n3", s_pc, 32'h300);

    // wrap at the top of the address space
    do_reset();
    step(1'b1, 1'b1, 32'hFFFF_FFF8);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("s5_pc0", s_pc, 32'hFFFF_FFF8);
    chk("s5_plus4_0", s_plus4, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 32'h0);
    chk("s5_pc1", s_pc, 32'hFFFF_FFFC);
    chk("s5_plus4_1", s_plus4, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("s5_pc2", s_pc, 32'h0);
    chk("s5_plus4_2", s_plus4, 32'h4);

    // misaligned redirect target
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h102);
`ifdef FETCH_MISALIGN_TRAP_EN
    step(1'b1, 1'b0, 32'h0);
    chk("s6_req_n1", s_req, 0);
    chk("s6_valid_n1", s_valid, 0);
    step(1'b1, 1'b0, 32'h0);
    chk("s6_valid_n2", s_valid, 1);
    chk("s6_fault", s_fault, 1);
    chk("s6_fault_pc", s_pc, 32'h102);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 32'h0);
      chk("s6_halt_req", s_req, 0);
      chk("s6_halt_valid", s_valid, 0);
    end
    step(1'b1, 1'b1, 32'h200);
    run_until_valid(20, n);
    chk("s6_resume_pc", s_pc, 32'h200);
    chk("s6_resume_fault", s_fault, 0);
`else
    step(1'b1, 1'b0, 32'h0);
    chk("s6_req", s_req, 1);
    chk("s6_addr", s_addr, 32'h100);
    run_until_valid(20, n);
    chk("s6_head_pc", s_pc, 32'h100);
    chk("s6_fault", s_fault, 0);
`endif

    // randomized traffic; the per-cycle model does the checking
    gnt_pct = 70; lat_lo = 1; lat_hi = 4;
    do_reset();
    n_deliv = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      if ($urandom_range(99) < 3) begin
        tgt = ($urandom_range(7) == 0) ? 32'hFFFF_FFF0 : (32'h0001_0000 | ($urandom & 32'h0000_FFFC));
        if ($urandom_range(9) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
        step(1'($urandom_range(3) != 0), 1'b1, tgt);
      end else begin
        step(1'($urandom_range(3) != 0), 1'b0, 32'h0);
      end
    end
    checks++;
    if (n_deliv < 200) begin
      errors++;
      $display("FAIL random_progress: got %0d deliveries expected at least 200", n_deliv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch stage with a prefetch queue, directly upstream of decode and immediate extension. Issues sequential 32-bit fetches to instruction memory over a request/grant/response handshake, buffers returned words with their PC in a DEPTH-entry FIFO, and presents them to decode with a valid/ready handshake. Branch and jump redirects flush the queue and discard in-flight responses.

## Interface
- DEPTH, 4: queue entries and maximum outstanding fetches; power of two, ≥2
- RESET_PC, 32'h0000_0000: first fetch address after reset
- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  synchronous, active-high reset
- imem_req_o  output  1  fetch request valid
- imem_addr_o  output  32  fetch address, word-aligned
- imem_gnt_i  input  1  request accepted this cycle when high together with imem_req_o
- imem_rvalid_i  input  1  response valid; responses return in request order, exactly one per grant
- imem_rdata_i  input  32  fetched instruction word
- redirect_i  input  1  flush and restart fetch (taken branch, jump, trap)
- redirect_pc_i  input  32  restart address
- instr_valid_o  output  1  queue head valid
- instr_ready_i  input  1  decode accepts head
- instr_o  output  32  head instruction word
- pc_o  output  32  head PC
- pc_plus4_o  output  32  pc_o + 4, modulo 2^32
- fault_o  output  1  head is a misaligned-fetch fault entry

## Operation
- State: fetch PC (fpc), FIFO (instr, pc, fault per entry) with rd/wr pointers and count, outstanding counter (out), discard counter (disc).
- Request: imem_req_o = !redirect_i && !halted && (count + out < DEPTH); imem_addr_o = fpc. On grant: fpc += 4 (wraps 32'hFFFF_FFFC -> 0), out += 1.
- Response: on imem_rvalid_i, out -= 1; if disc > 0, disc -= 1 and data dropped; else push {imem_rdata_i, pc of that request, 0}. Entry PC tracked by a response-PC register advanced by 4 per accepted response.
- Credit rule guarantees a push never occurs when full; response while out == 0 is a protocol error (assertion), ignored.
- Pop: on instr_valid_o && instr_ready_i; push and pop in same cycle allowed, count unchanged.
- Redirect (highest priority): FIFO cleared (count 0, pointers reset), fpc and response-PC = redirect_pc_i, disc = out + disc after this cycle's response/grant accounting (grant is impossible since req is low), halted cleared. Pop in the redirect cycle is discarded.
- Decode-side outputs come directly from the FIFO head register; no bypass from imem_rdata_i.

## Timing
- Reset: imem_req_o 0 during reset; instr_valid_o 0, instr_o 0, pc_o 0, pc_plus4_o 4, fault_o 0; fpc = RESET_PC, out = disc = count = 0. First request in the cycle after rst_i falls.
- Reset mid-operation: all in-flight responses are forgotten; memory must be reset with this block.
- Response in cycle N -> instr_valid_o in N+1.
- Redirect in cycle N -> request at redirect_pc_i in N+1; with 1-cycle memory (grant N+1, rvalid N+2), instr_valid_o in N+3.
- Steady state with 1-cycle memory and decode always ready: one instruction per cycle.
- Decode stall: requests stop once count + out = DEPTH; resume the cycle after a pop frees credit.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined: redirect with redirect_pc_i[1:0] != 0 sets halted (no requests), and in the next cycle pushes one entry {instr 0, pc = redirect_pc_i, fault 1}; fault_o high while it is head; stays halted until next redirect.
- Undefined: redirect_pc_i[1:0] forced to 00, halted never set, fault_o tied 0.

## Test plan
- Reset, memory grants every cycle with 1-cycle rvalid, decode ready -> PCs 0,4,8,... on consecutive cycles from cycle 3; instr_o matches memory.
- Decode ready low for 10 cycles -> exactly DEPTH=4 grants, instr_valid_o held on pc 0; ready high -> remaining in order, no loss or duplicate.
- Memory latency 3 cycles, redirect to 32'h100 with 3 outstanding -> those 3 responses dropped, next head pc_o = 32'h100.
- Redirect coincident with pop and rvalid -> neither popped entry nor response appears; first valid after is redirect target.
- Redirect to 32'hFFFF_FFF8 -> PCs FFFF_FFF8, FFFF_FFFC, 0000_0000; pc_plus4_o at FFFF_FFFC is 0.
- With FETCH_MISALIGN_TRAP_EN, redirect to 32'h102 -> single entry fault_o=1, pc_o=32'h102, no imem_req_o until redirect to 32'h200; without macro, fetch resumes at 32'h100.
